// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises a raw switch vector and debounces it as a unit,
// emitting a stable value plus one-cycle change, rise and fall strobes.
module switch_debouncer #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             busy
);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       COUNT    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Any movement of the whole vector away from the candidate restarts qualification.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        rise_d    = '0;
        fall_d    = '0;
        if (state_q == IDLE) begin
            if (s2_q != stable_q) begin
                cand_d  = s2_q;
                cnt_d   = '0;
                state_d = COUNT;
            end
        end else if (s2_q == stable_q) begin
            state_d = IDLE;
        end else if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d  = cand_q;
            changed_d = 1'b1;
            rise_d    = cand_q & ~stable_q;
            fall_d    = ~cand_q & stable_q;
            state_d   = IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            stable_q  <= '0;
            changed_q <= 1'b0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign sw_stable  = stable_q;
    assign sw_changed = changed_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign busy       = (state_q == COUNT);
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed plus randomized stimulus checked against a
// run-length reference model of the debouncer.
module tb_switch_debouncer;
    localparam int W = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_changed, busy;

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(sw_stable),
        .sw_changed(sw_changed), .sw_rise(sw_rise), .sw_fall(sw_fall), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the synchronised value is accepted once D+1 consecutive samples agree and differ from stable.
    logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
    logic         m_chg, m_busy;
    logic [W-1:0] hist[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        m_chg = 1'b0; m_busy = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic [W-1:0] smp;
        logic         acc;
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = sw_raw;
        hist.push_back(smp);
        if (hist.size() > D + 1) void'(hist.pop_front());
        acc = (hist.size() == D + 1) && (smp != m_stable);
        foreach (hist[i]) if (hist[i] != smp) acc = 1'b0;
        m_busy = (smp != m_stable) && !acc;
        m_chg  = acc;
        m_rise = acc ? (smp & ~m_stable) : '0;
        m_fall = acc ? (~smp & m_stable) : '0;
        if (acc) m_stable = smp;
    endtask

    task automatic check_all();
        chk("stable", 32'(sw_stable), 32'(m_stable));
        chk("changed", 32'(sw_changed), 32'(m_chg));
        chk("rise", 32'(sw_rise), 32'(m_rise));
        chk("fall", 32'(sw_fall), 32'(m_fall));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic cycle(input logic [W-1:0] v);
        sw_raw = v;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(v);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_stable", 32'(sw_stable), 0);
        chk("rst_changed", 32'(sw_changed), 0);
        chk("rst_rise", 32'(sw_rise), 0);
        chk("rst_fall", 32'(sw_fall), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int first;
        int pulses;
        model_reset();
        @(posedge clk);
        #1 do_reset();
        hold('0, 20);

        // Clean step: stable must appear on edge D+3 with a single strobe.
        first = 0;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            cycle(5'b00011);
            if (sw_changed) pulses++;
            if (first == 0 && sw_stable == 5'b00011) first = e;
        end
        chk("step_latency", 32'(first), 32'(D + 3));
        chk("step_pulses", 32'(pulses), 1);

        hold(5'b00010, 2);
        hold(5'b00011, 10);
        chk("bounce_kept", 32'(sw_stable), 3);

        hold('0, 10);
        hold(5'b00001, 2);
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            cycle(5'b00010);
            if (sw_stable == 5'b00001) chk("never_one", 32'(sw_stable), 2);
            if (first == 0 && sw_stable == 5'b00010) first = e;
        end
        chk("restart_latency", 32'(first), 32'(D + 3));

        for (int v = 0; v <= 5; v++) hold(W'(v), 10);
        chk("seq_end", 32'(sw_stable), 5);

        hold(5'b00010, 10);
        hold(5'b00101, 4);
        chk("mid_busy", 32'(busy), 1);
        do_reset();
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            cycle(5'b00101);
            if (first == 0 && sw_stable == 5'b00101) first = e;
        end
        chk("post_rst_latency", 32'(first), 32'(D + 3));

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(49) == 0) do_reset();
            hold(W'($urandom_range(7)), int'($urandom_range(1, 10)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the slide-switch bank that feeds the switch-to-seven-segment encoder.
- Synchronises the asynchronous raw switch vector into the clock domain and debounces the whole vector as a unit.
- Presents a glitch-free stable value, plus per-bit rise/fall strobes and a one-cycle change strobe.
- The encoder consumes sw_stable directly as its sw input.

Parameters:
- WIDTH, 5: number of switch bits; matches the encoder's 5-bit sw input.
- DEBOUNCE_CYCLES, 500000: consecutive clock cycles the synchronised input must hold a new value before acceptance (10 ms at 50 MHz). Legal range is >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): derived counter width. Never overridden.

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst, input, 1: reset, asynchronous, active-high.
- sw_raw, input, WIDTH: raw switch pins, asynchronous to clk.
- sw_stable, output, WIDTH: debounced switch value; feeds the encoder.
- sw_changed, output, 1: one-cycle pulse in the cycle sw_stable takes a new value.
- sw_rise, output, WIDTH: one-cycle per-bit pulse for bits that went 0->1 on that update.
- sw_fall, output, WIDTH: one-cycle per-bit pulse for bits that went 1->0 on that update.
- busy, output, 1: high while a candidate value is being qualified (state COUNT).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset clears all registers immediately and asynchronously:
  - sync stages, candidate, counter, sw_stable, sw_changed, sw_rise, sw_fall, busy all = 0.
  - State = IDLE.
  - Reset asserted mid-count abandons the candidate; no strobe is produced.
- Synchroniser: two-flop chain sw_raw -> s1 -> s2. All decisions use s2 only.
- FSM, state IDLE (busy = 0):
  - If s2 != sw_stable: candidate <= s2, cnt <= 0, go to COUNT.
  - Otherwise remain in IDLE.
- FSM, state COUNT (busy = 1):
  - If s2 == sw_stable: glitch has reverted. Go to IDLE with no update and no strobes.
  - Else if s2 != candidate: input moved to a different new value. candidate <= s2, cnt <= 0, stay in COUNT.
  - Else if cnt == DEBOUNCE_CYCLES-1:
    - sw_stable <= candidate.
    - sw_changed <= 1.
    - sw_rise <= candidate & ~sw_stable.
    - sw_fall <= ~candidate & sw_stable.
    - Go to IDLE.
  - Else cnt <= cnt + 1.
- Strobes (sw_changed, sw_rise, sw_fall) are registered, high for exactly one cycle, and 0 in every other cycle.
- Latency: for a clean step on sw_raw, sw_stable updates on rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples the new value as edge 1. sw_changed is high for the cycle following that edge.
- Counter:
  - Saturation is unreachable by construction.
  - Counter width is CNT_W bits; no overflow or wrap within legal parameters.
- Multi-bit handling: a change on any bit during COUNT restarts qualification for the whole vector. Bits are never accepted individually.
- Back-to-back changes: a new difference seen in IDLE on the cycle after an update starts a fresh COUNT normally.
- sw_stable changes only on accepted updates. It never glitches, including during reset release.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, then hold sw_raw = 0 for 20 cycles -> sw_stable = 0, busy = 0, no strobes.
- Clean step sw_raw 0 -> 5'b00011 -> sw_stable = 3 at edge 7 after the change; sw_changed pulses 1 cycle; sw_rise = 5'b00011, sw_fall = 0.
- Bounce: from stable 3, sw_raw = 5'b00010 for 2 cycles, then back to 3 -> busy rises then falls; sw_stable stays 3; no strobes.
- Restart: from stable 0, drive 1, then 2 after 2 cycles, then hold 2 -> sw_stable = 2 at 4+3 edges after the switch to 2; sw_rise = 5'b00010; value 1 is never output.
- Sequence 0, 1, 2, 3, 4, 5, each held 10 cycles -> sw_stable steps through 0..5. Each step gives one sw_changed pulse with correct rise/fall masks (e.g. 3 -> 4: rise = 5'b00100, fall = 5'b00011).
- Assert rst during COUNT (candidate 5) -> all outputs 0 immediately. After release with sw_raw = 5 held, sw_stable = 5 after 7 edges.
